// File: rtl/cpu7_dbus_sram_resp.sv
// cpu7_dbus_sram_resp
//   Responder for the cpu7 data-side bus in no-cache builds. Accepts one request at a
//   time, performs it on a single-port synchronous SRAM and returns the response. It
//   also tracks the ll/sc link, handles request cancellation and raises an address
//   exception (ADEM) for accesses outside the SRAM window.
//
// Ports
//   clk, resetn                        clock, asynchronous active-low reset
//   data_req/wr/prefetch/ll/sc         request qualifiers
//   data_addr/wdata/pc, data_wstrb     byte address, store data, PC (unused), byte enables
//   data_cancel, data_cancel_ex2       kill the in-flight request (ORed)
//   data_recv                          consumer accepts the response
//   data_addr_ok, data_data_ok         request accept, response valid
//   data_rdata, data_badvaddr          load data, faulting address
//   data_exception, data_exccode       fault flag and code
//   data_scsucceed                     sc result, valid with data_data_ok
//   data_req_empty                     no request in flight
//   ram_en/we/addr/wdata, ram_rdata    SRAM command and read data (read data one cycle later)

module cpu7_dbus_sram_resp #(
    parameter int unsigned MEM_LAT = 0,
    parameter int unsigned ADDR_W  = 14,
    parameter logic [31:0] BASE    = 32'h1c000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic              data_prefetch,
    input  logic              data_ll,
    input  logic              data_sc,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [31:0]       data_pc,
    input  logic [3:0]        data_wstrb,
    input  logic              data_cancel,
    input  logic              data_cancel_ex2,
    input  logic              data_recv,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic [31:0]       data_badvaddr,
    output logic              data_exception,
    output logic [5:0]        data_exccode,
    output logic              data_scsucceed,
    output logic              data_req_empty,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [2:0] LatInit = 3'(MEM_LAT);
    localparam logic [5:0] ExcAdem = 6'h08;

    typedef enum logic [1:0] {StIdle, StWait, StLoad, StResp} state_e;

    state_e      state_q, state_d;
    logic        rst_done_q, rst_done_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;          // word address
    logic        wr_q, wr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ll_q, ll_d;
    logic        sc_q, sc_d;
    logic        cancel_q, cancel_d;
    logic        link_q, link_d;
    logic [29:0] link_addr_q, link_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        exc_q, exc_d;
    logic [5:0]  exccode_q, exccode_d;
    logic        scsucceed_q, scsucceed_d;

    logic cancel_in;
    logic hit;
    logic issue;
    logic issue_kill;
    logic is_write;
    logic sc_ok;
    logic unused_pc;

    assign unused_pc  = ^data_pc;

    assign cancel_in  = data_cancel | data_cancel_ex2;
    assign hit        = (data_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign issue      = (state_q == StWait) && (cnt_q == 3'd0);
    // A cancel seen in the issue cycle itself must still suppress the write.
    assign issue_kill = cancel_q | cancel_in;
    assign is_write   = wr_q | sc_q;
    assign sc_ok      = link_q && (link_addr_q == addr_q);

    assign data_addr_ok   = (state_q == StIdle) && rst_done_q;
    assign data_req_empty = (state_q == StIdle);
    assign data_data_ok   = (state_q == StResp) && !cancel_q;
    assign data_rdata     = rdata_q;
    assign data_badvaddr  = badvaddr_q;
    assign data_exception = exc_q;
    assign data_exccode   = exccode_q;
    assign data_scsucceed = scsucceed_q;

    assign ram_en    = issue;
    assign ram_addr  = addr_q[ADDR_W-1:0];
    assign ram_wdata = wdata_q;

    always_comb begin
        ram_we = 4'b0000;
        // A failing sc is issued as a read so the SRAM access pattern stays uniform.
        if (issue && is_write && !issue_kill && (!sc_q || sc_ok)) begin
            ram_we = wstrb_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_done_d  = 1'b1;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        ll_d        = ll_q;
        sc_d        = sc_q;
        cancel_d    = cancel_q;
        link_d      = link_q;
        link_addr_d = link_addr_q;
        rdata_d     = rdata_q;
        badvaddr_d  = badvaddr_q;
        exc_d       = exc_q;
        exccode_d   = exccode_q;
        scsucceed_d = scsucceed_q;

        case (state_q)
            StIdle: begin
                // Prefetches are accepted and dropped without touching any state.
                if (data_req && data_addr_ok && !data_prefetch) begin
                    addr_d      = data_addr[31:2];
                    wr_d        = data_wr;
                    wstrb_d     = data_wstrb;
                    wdata_d     = data_wdata;
                    ll_d        = data_ll;
                    sc_d        = data_sc;
                    cnt_d       = LatInit;
                    cancel_d    = 1'b0;
                    rdata_d     = 32'h0;
                    scsucceed_d = 1'b0;
                    if (hit) begin
                        state_d    = StWait;
                        exc_d      = 1'b0;
                        exccode_d  = 6'h00;
                        badvaddr_d = 32'h0;
                    end else begin
                        state_d    = StResp;
                        exc_d      = 1'b1;
                        exccode_d  = ExcAdem;
                        badvaddr_d = data_addr;
                    end
                end
            end
            StWait: begin
                if (cancel_in) begin
                    cancel_d = 1'b1;
                end
                if (cnt_q == 3'd0) begin
                    state_d = StLoad;
                    // Link is only updated by requests that are still alive at issue.
                    if (!issue_kill) begin
                        if (sc_q) begin
                            link_d      = 1'b0;
                            scsucceed_d = sc_ok;
                        end else if (wr_q) begin
                            if (addr_q == link_addr_q) begin
                                link_d = 1'b0;
                            end
                        end else if (ll_q) begin
                            link_d      = 1'b1;
                            link_addr_d = addr_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StLoad: begin
                if (cancel_in) begin
                    cancel_d = 1'b1;
                end
                rdata_d = is_write ? 32'h0 : ram_rdata;
                state_d = StResp;
            end
            StResp: begin
                if (cancel_q || data_recv) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            rst_done_q  <= 1'b0;
            cnt_q       <= 3'd0;
            addr_q      <= 30'h0;
            wr_q        <= 1'b0;
            wstrb_q     <= 4'h0;
            wdata_q     <= 32'h0;
            ll_q        <= 1'b0;
            sc_q        <= 1'b0;
            cancel_q    <= 1'b0;
            link_q      <= 1'b0;
            link_addr_q <= 30'h0;
            rdata_q     <= 32'h0;
            badvaddr_q  <= 32'h0;
            exc_q       <= 1'b0;
            exccode_q   <= 6'h00;
            scsucceed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_done_q  <= rst_done_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            ll_q        <= ll_d;
            sc_q        <= sc_d;
            cancel_q    <= cancel_d;
            link_q      <= link_d;
            link_addr_q <= link_addr_d;
            rdata_q     <= rdata_d;
            badvaddr_q  <= badvaddr_d;
            exc_q       <= exc_d;
            exccode_q   <= exccode_d;
            scsucceed_q <= scsucceed_d;
        end
    end

endmodule
